// File: rtl/gol_pixel_renderer.sv
// Game of Life pixel renderer: maps VGA h/v counts to grid-memory reads and
// per-pixel RGB through a fixed 3-clock pipeline with sync re-timed alongside.
module gol_pixel_renderer #(
  parameter int CELL_SHIFT = 4,
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int ADDR_W     = 11,
  parameter int GRID_LINES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       h_count,
  input  logic [15:0]       v_count,
  output logic [ADDR_W-1:0] cell_addr,
  output logic              cell_rd_en,
  input  logic              cell_data,
  output logic              hsync_vga,
  output logic              vsync_vga,
  output logic [3:0]        r_vga,
  output logic [3:0]        g_vga,
  output logic [3:0]        b_vga,
  output logic              vblank_start
);

  localparam int XW = 10;
  localparam int CW = XW - CELL_SHIFT;

  logic              active_s0;
  logic [XW-1:0]     x_s0;
  logic [XW-1:0]     y_s0;
  logic [CW-1:0]     col_s0;
  logic [CW-1:0]     row_s0;
  logic [ADDR_W-1:0] addr_s0;
  logic              edge_s0;
  logic              hs_s0;
  logic              vs_s0;
  logic              eoav_s0;

  logic              edge_s1;
  logic              hs_s1;
  logic              vs_s1;
  logic              eoav_s1;

  logic              act_s2;
  logic              edge_s2;
  logic              hs_s2;
  logic              vs_s2;
  logic              eoav_s2;

  logic [3:0]        level;

  // The row/col bound also keeps the address inside the grid if the
  // parameters are ever set so the grid is smaller than the visible area.
  always_comb begin
    active_s0 = (h_count >= 16'd144) && (h_count <= 16'd783) &&
                (v_count >= 16'd35)  && (v_count <= 16'd514);
    x_s0      = XW'(h_count - 16'd144);
    y_s0      = XW'(v_count - 16'd35);
    col_s0    = x_s0[XW-1:CELL_SHIFT];
    row_s0    = y_s0[XW-1:CELL_SHIFT];
    active_s0 = active_s0 && (col_s0 < CW'(GRID_W)) && (row_s0 < CW'(GRID_H));
    addr_s0   = ADDR_W'(row_s0) * ADDR_W'(GRID_W) + ADDR_W'(col_s0);
    edge_s0   = (GRID_LINES != 0) && active_s0 &&
                ((x_s0[CELL_SHIFT-1:0] == '0) || (y_s0[CELL_SHIFT-1:0] == '0));
    hs_s0     = (h_count < 16'd96);
    vs_s0     = (v_count < 16'd2);
    eoav_s0   = (h_count == 16'd0) && (v_count == 16'd515);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_addr  <= '0;
      cell_rd_en <= 1'b0;
      edge_s1    <= 1'b0;
      hs_s1      <= 1'b0;
      vs_s1      <= 1'b0;
      eoav_s1    <= 1'b0;
    end else begin
      if (active_s0) begin
        cell_addr <= addr_s0;
      end
      cell_rd_en <= active_s0;
      edge_s1    <= edge_s0;
      hs_s1      <= hs_s0;
      vs_s1      <= vs_s0;
      eoav_s1    <= eoav_s0;
    end
  end

  // Memory is busy returning cell_data during this stage; everything else waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_s2  <= 1'b0;
      edge_s2 <= 1'b0;
      hs_s2   <= 1'b0;
      vs_s2   <= 1'b0;
      eoav_s2 <= 1'b0;
    end else begin
      act_s2  <= cell_rd_en;
      edge_s2 <= edge_s1;
      hs_s2   <= hs_s1;
      vs_s2   <= vs_s1;
      eoav_s2 <= eoav_s1;
    end
  end

  always_comb begin
    level = 4'h0;
    if (act_s2) begin
      if (cell_data) begin
        level = 4'hF;
      end else if (edge_s2) begin
        level = 4'h2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vga        <= 4'h0;
      g_vga        <= 4'h0;
      b_vga        <= 4'h0;
      hsync_vga    <= 1'b0;
      vsync_vga    <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      r_vga        <= level;
      g_vga        <= level;
      b_vga        <= level;
      hsync_vga    <= hs_s2;
      vsync_vga    <= vs_s2;
      vblank_start <= eoav_s2;
    end
  end

endmodule

// File: tb/tb_gol_pixel_renderer.sv
// Self-checking bench for gol_pixel_renderer: one instance with grid lines,
// one without, both compared against a per-pixel reference model.
module tb_gol_pixel_renderer;

  logic        clock = 1'b0;
  logic        rstN;
  logic [15:0] hCount;
  logic [15:0] vCount;

  logic [10:0] cellAddr, cellAddr0;
  logic        cellRdEn, cellRdEn0;
  logic        cellData = 1'b0, cellData0 = 1'b0;
  logic        hsync, vsync, vblank, hsync0, vsync0, vblank0;
  logic [3:0]  r, g, b, r0, g0, b0;

  bit          aliveMem [0:2047];

  typedef struct packed {
    logic [3:0] lvl1;
    logic [3:0] lvl0;
    logic       hs;
    logic       vs;
    logic       vb;
  } expT;

  expT  expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   expAddr = 0;
  logic expRdEn = 1'b0;
  int   maxAddr = 0;
  int   vbSeen = 0;
  int   vbExpected = 0;

  always #20 clock = ~clock;

  // Synchronous-read grid memory: data is valid one clock after the address.
  always @(posedge clock) if (cellRdEn) cellData <= aliveMem[cellAddr];
  always @(posedge clock) if (cellRdEn0) cellData0 <= aliveMem[cellAddr0];

  gol_pixel_renderer #(.GRID_LINES(1)) dut (
    .clk(clock), .rst_n(rstN), .h_count(hCount), .v_count(vCount),
    .cell_addr(cellAddr), .cell_rd_en(cellRdEn), .cell_data(cellData),
    .hsync_vga(hsync), .vsync_vga(vsync), .r_vga(r), .g_vga(g), .b_vga(b),
    .vblank_start(vblank)
  );

  gol_pixel_renderer #(.GRID_LINES(0)) dut0 (
    .clk(clock), .rst_n(rstN), .h_count(hCount), .v_count(vCount),
    .cell_addr(cellAddr0), .cell_rd_en(cellRdEn0), .cell_data(cellData0),
    .hsync_vga(hsync0), .vsync_vga(vsync0), .r_vga(r0), .g_vga(g0), .b_vga(b0),
    .vblank_start(vblank0)
  );

  function automatic bit isActive(int h, int v);
    return (h >= 144) && (h <= 783) && (v >= 35) && (v <= 514);
  endfunction

  // Expected outputs for one pixel, straight from the display rules.
  function automatic expT model(int h, int v);
    expT e;
    int  x, y;
    x = h - 144;
    y = v - 35;
    e.hs   = (h < 96);
    e.vs   = (v < 2);
    e.vb   = (h == 0) && (v == 515);
    e.lvl1 = 4'h0;
    e.lvl0 = 4'h0;
    if (isActive(h, v)) begin
      if (aliveMem[(y / 16) * 40 + x / 16]) begin
        e.lvl1 = 4'hF;
        e.lvl0 = 4'hF;
      end else if ((x % 16 == 0) || (y % 16 == 0)) begin
        e.lvl1 = 4'h2;
      end
    end
    return e;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    expT e;
    checkVal("rd_en", 32'(cellRdEn), 32'(expRdEn));
    checkVal("addr", 32'(cellAddr), expAddr);
    checkVal("rd_en0", 32'(cellRdEn0), 32'(expRdEn));
    checkVal("addr0", 32'(cellAddr0), expAddr);
    if (32'(cellAddr) > maxAddr) maxAddr = 32'(cellAddr);
    if (vblank) vbSeen++;
    if (expQ.size() == 3) begin
      e = expQ.pop_front();
      checkVal("r", 32'(r), 32'(e.lvl1));
      checkVal("g", 32'(g), 32'(e.lvl1));
      checkVal("b", 32'(b), 32'(e.lvl1));
      checkVal("hsync", 32'(hsync), 32'(e.hs));
      checkVal("vsync", 32'(vsync), 32'(e.vs));
      checkVal("vblank", 32'(vblank), 32'(e.vb));
      checkVal("r_nolines", 32'(r0), 32'(e.lvl0));
      checkVal("g_nolines", 32'(g0), 32'(e.lvl0));
      checkVal("b_nolines", 32'(b0), 32'(e.lvl0));
      checkVal("hsync_nolines", 32'(hsync0), 32'(e.hs));
      checkVal("vsync_nolines", 32'(vsync0), 32'(e.vs));
      checkVal("vblank_nolines", 32'(vblank0), 32'(e.vb));
    end else begin
      checkVal("pipe_depth", expQ.size(), 3);
    end
  endtask

  task automatic applyStimulus(input int h, input int v);
    hCount = 16'(h);
    vCount = 16'(v);
    expQ.push_back(model(h, v));
    if ((h == 0) && (v == 515)) vbExpected++;
    expRdEn = isActive(h, v);
    if (expRdEn) expAddr = ((v - 35) / 16) * 40 + (h - 144) / 16;
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic checkZero(input string tag);
    checkVal({tag, "_r"}, 32'(r), 0);
    checkVal({tag, "_g"}, 32'(g), 0);
    checkVal({tag, "_b"}, 32'(b), 0);
    checkVal({tag, "_hs"}, 32'(hsync), 0);
    checkVal({tag, "_vs"}, 32'(vsync), 0);
    checkVal({tag, "_vb"}, 32'(vblank), 0);
    checkVal({tag, "_rd"}, 32'(cellRdEn), 0);
    checkVal({tag, "_addr"}, 32'(cellAddr), 0);
  endtask

  // Reset asserted between edges must clear everything without a clock.
  task automatic doReset();
    rstN = 1'b0;
    #5;
    checkZero("rst_async");
    hCount = 16'd200;
    vCount = 16'd100;
    repeat (2) @(posedge clock);
    #1;
    checkZero("rst_held");
    expQ.delete();
    expQ.push_back('0);
    expQ.push_back('0);
    expAddr = 0;
    expRdEn = 1'b0;
  endtask

  task automatic setMem(input bit randomFill, input int target);
    for (int i = 0; i < 2048; i++) begin
      aliveMem[i] = randomFill ? bit'($urandom_range(0, 1)) : (i == target);
    end
  endtask

  task automatic flush();
    repeat (3) applyStimulus(799, 524);
  endtask

  task automatic lineSweep(input int v);
    for (int h = 0; h < 800; h++) applyStimulus(h, v);
  endtask

  initial begin
    setMem(1'b0, 163);
    hCount = 16'd200;
    vCount = 16'd100;
    doReset();
    rstN = 1'b1;
    repeat (6) applyStimulus(200, 100);

    flush();
    setMem(1'b0, 5);
    lineSweep(35);
    applyStimulus(144, 35);
    checkVal("corner_first", 32'(cellAddr), 0);
    applyStimulus(783, 514);
    checkVal("corner_last", 32'(cellAddr), 1199);

    flush();
    setMem(1'b0, -1);
    lineSweep(36);
    lineSweep(51);
    lineSweep(514);

    applyStimulus(300, 200);
    doReset();
    rstN = 1'b1;
    applyStimulus(400, 300);

    flush();
    setMem(1'b1, -1);
    lineSweep(0);
    lineSweep(1);
    lineSweep(2);
    lineSweep(34);
    lineSweep(515);
    lineSweep(524);
    for (int i = 0; i < 4; i++) lineSweep($urandom_range(35, 514));
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) applyStimulus(0, 515);
      else applyStimulus($urandom_range(0, 1023), $urandom_range(0, 1023));
    end
    flush();

    checkVal("vblank_pulses", vbSeen, vbExpected);
    checkVal("addr_in_range", 32'(maxAddr <= 1199), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gol_pixel_renderer.md
Name: gol_pixel_renderer

Overview:
- Converts the 800x525 VGA timing counts into per-pixel RGB for the Game of Life display.
- Reads the cell-state grid memory and draws each cell as a CELL_PX x CELL_PX block, with optional grid lines.
- Sits between the horizontal/vertical counters (upstream) and the VGA output pins (downstream).
- Re-times hsync/vsync so sync and colour leave aligned, and tells the life engine when vertical blanking begins.

Parameters:
- CELL_SHIFT, 4: log2 of cell size in pixels (16x16 cells).
- GRID_W, 40: cells per row (640 >> CELL_SHIFT).
- GRID_H, 30: cells per column (480 >> CELL_SHIFT).
- ADDR_W, 11: cell address width; must satisfy 2^ADDR_W >= GRID_W*GRID_H.
- GRID_LINES, 1: 1 = draw dim lines on cell borders; 0 = off.

Ports:
- clk  input  1  pixel-rate clock (25 MHz), shared with the counters.
- rst_n  input  1  asynchronous active-low reset.
- h_count  input  16  horizontal count 0..799 from the horizontal counter.
- v_count  input  16  vertical count 0..524 from the vertical counter.
- cell_addr  output  ADDR_W  grid memory read address = row*GRID_W + col.
- cell_rd_en  output  1  read strobe; high only for active-video pixels.
- cell_data  input  1  cell state (1 = alive); valid exactly 1 clk after cell_addr/cell_rd_en.
- hsync_vga  output  1  hsync, high while the aligned h_count < 96.
- vsync_vga  output  1  vsync, high while the aligned v_count < 2.
- r_vga  output  4  red.
- g_vga  output  4  green.
- b_vga  output  4  blue.
- vblank_start  output  1  one-clk pulse on the first pixel after active video ends (aligned h=0, v=515).

Behaviour:
- Active region: 144 <= h_count <= 783 and 35 <= v_count <= 514 (640x480). Outside it, RGB = 0.
- Stage 0 (combinational → registered at edge 1):
  - active = region test above.
  - x = h_count - 144, y = v_count - 35, both truncated to 10 bits.
  - col = x >> CELL_SHIFT, row = y >> CELL_SHIFT.
  - cell_addr <= row*GRID_W + col, cell_rd_en <= active.
  - When inactive: cell_addr holds its last value and cell_rd_en = 0.
  - Register edge_px = GRID_LINES && active && (x[CELL_SHIFT-1:0]==0 || y[CELL_SHIFT-1:0]==0).
  - Register raw hsync (h<96), raw vsync (v<2), and eoav (h==0 && v==515).
- Stage 1 (edge 2): memory returns cell_data. The pipeline delays active, edge_px and the sync bits by one more register.
- Stage 2 (edge 3), output registers, in priority order:
  - !active → RGB = 0.
  - cell_data = 1 → RGB = F,F,F.
  - edge_px → RGB = 2,2,2.
  - otherwise → RGB = 0.
- Latency: every output reflects the h/v count presented 3 clks earlier. hsync/vsync/RGB/vblank_start stay mutually aligned, with no sync-to-colour skew.
- vblank_start is high for exactly one clk per frame, 3 clks after the counters read h=0, v=515.
- Address range:
  - Max address = (GRID_H-1)*GRID_W + GRID_W-1 = 1199 with defaults.
  - The block never issues an address >= GRID_W*GRID_H.
- Counter wrap:
  - h 799→0 and v 524→0 need no special handling; the pipeline is free-running and stateless across frames.
  - Out-of-range counts (h>799 or v>524) are treated as inactive, non-sync.
- Reset (async, rst_n=0):
  - All pipeline and output registers clear immediately: RGB = 0, hsync_vga = 0, vsync_vga = 0, cell_rd_en = 0, cell_addr = 0, vblank_start = 0.
- Reset released mid-frame:
  - Outputs resume from whatever counts are present.
  - First valid (non-reset) output appears at the 3rd rising edge after release.
  - No partial frame suppression.

Test Plan:
- Reset: hold rst_n=0 with h=200, v=100 → all outputs 0 and cell_rd_en=0. Release → 3 clks later RGB reflects the cell at addr (100-35>>4)*40 + (200-144>>4) = 4*40+3 = 163.
- Address/latency: sweep h=144..783 at v=35 with memory returning 1 only at addr 5 → cell_addr steps 0..39; RGB=F only for h=224..239, appearing 3 clks after those counts.
- Grid lines: GRID_LINES=1, all cells dead → RGB=2 at x%16==0 or y%16==0 inside active, 0 elsewhere. With GRID_LINES=0 → all 0.
- Blanking/sync: run a full 800x525 frame → hsync_vga high for 96 clks per line, vsync_vga high for 2 lines, RGB=0 and cell_rd_en=0 outside the active region, and all sync edges delayed 3 clks from the counts.
- vblank_start: two consecutive frames → exactly one pulse per frame, 420000 clks apart, 3 clks after h=0, v=515.
- Corner addresses: h=783, v=514 → cell_addr=1199; h=144, v=35 → cell_addr=0. Address never exceeds 1199 over a full frame.
